// File: rtl/uart_pkg.sv
// Shared definitions for the uart receive and transmit paths: default framing
// constants and the receiver state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// Byte-side handshake and status bundle of the uart receiver. The master side
// is the receiver and the slave side is the byte consumer.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output data_ready
  );

endinterface : uart_receiver_if

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so idle-high lines come out of reset looking idle.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is written with non-blocking assignments so both
  // flops sample the values from before the edge, forming a real two-stage chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : uart_sync2

// File: rtl/uart_receiver.sv
// 8N1-style uart receive endpoint: oversampled start/data/stop detection with a
// registered valid/ready byte output, framing-error pulse and sticky overrun.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  uart_receiver_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 rx_s, rx_s_d, fall;
  logic                 byte_done, stop_fail;
  logic                 accept;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_s_d <= 1'b1;
    else        rx_s_d <= rx_s;
  end

  assign fall = rx_s_d & ~rx_s;

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    byte_done   = 1'b0;
    stop_fail   = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (fall) state_nxt = START;
      end

      // Mid-start-bit check: a line that is high again was only a glitch.
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt   = IDLE;
          end
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + 1'b1;
        end
      end

      // Returning to IDLE at the stop-bit centre leaves half a bit of margin
      // to catch a start bit that directly follows.
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_fail = 1'b1;
            state_nxt = BREAK;
          end
        end
      end

      BREAK: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end

      default: begin
        clk_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign accept = bus.data_valid & bus.data_ready;

  // Byte delivery: a pending byte is only replaced when it is being accepted
  // in the same cycle; otherwise the new byte is dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err <= stop_fail;

      if (byte_done && (!bus.data_valid || bus.data_ready)) begin
        bus.data_out   <= shift_reg;
        bus.data_valid <= 1'b1;
      end else if (accept) begin
        bus.data_valid <= 1'b0;
      end

      if (accept)                         bus.overrun <= 1'b0;
      else if (byte_done && bus.data_valid) bus.overrun <= 1'b1;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: drives serial frames on rx and checks
// delivered bytes against a queue of expected values plus the status flags.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int DB  = 8;
  // rx falling edge to data_valid: 3 edge latency, half bit, DB data bits and stop.
  localparam int LAT = 3 + CPB / 2 + (DB + 1) * CPB;

  logic clk = 1'b0;
  logic reset;
  logic rx;

  uart_receiver_if #(.DATA_BITS(DB)) bus ();

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fe_cnt  = 0;
  int dv_rise = 0;
  logic dv_prev = 1'b0;
  logic [DB-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.data_valid === 1'b1 && dv_prev !== 1'b1) dv_rise++;
    dv_prev = bus.data_valid;
  end

  // Drives start bit, payload LSB first and the given stop bit; call at a negedge.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit);
    logic [DB+1:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < DB + 2; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_exp(output logic [DB-1:0] b);
    if (exp_q.size() > 0) b = exp_q.pop_front();
    else                  b = 'x;
  endtask

  task automatic accept_byte();
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.data_valid); end
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", bus.data_out); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int start;
    bit ok;
    logic [DB-1:0] e;
    fe_cnt = 0;
    exp_q.push_back(8'hF5);
    start = cyc;
    fork
      send_frame(8'hF5, 1'b1);
    join_none
    wait_valid(LAT + 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout got no data_valid want data_valid"); end
    n_tests++; if (cyc - start !== LAT) begin n_fail++; $display("FAIL single_latency got %0d want %0d", cyc - start, LAT); end
    pop_exp(e);
    n_tests++; if (bus.data_out !== e) begin n_fail++; $display("FAIL single_data got %h want %h", bus.data_out, e); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun got %b want 0", bus.overrun); end
    wait fork;
    repeat (20) @(negedge clk);
    n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold got %b want 1", bus.data_valid); end
    n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL single_frame_err got %0d pulses want 0", fe_cnt); end
    accept_byte();
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b want 0", bus.data_valid); end
    n_tests++; if (bus.data_out !== 8'hF5) begin n_fail++; $display("FAIL single_keep got %h want f5", bus.data_out); end
  endtask

  task automatic test_glitch();
    int start;
    bit busy_seen;
    fe_cnt = 0;
    dv_rise = 0;
    busy_seen = 1'b0;
    start = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    busy_seen = bus.busy;
    // Start check lands at T0+8 = start+11; IDLE is visible from start+12.
    repeat (start + 12 - cyc) @(negedge clk);
    n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high got %b want 1", busy_seen); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle got %b want 0", bus.busy); end
    repeat (3 * CPB) @(negedge clk);
    n_tests++; if (dv_rise !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d deliveries want 0", dv_rise); end
    n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL glitch_frame_err got %0d pulses want 0", fe_cnt); end
  endtask

  task automatic test_framing();
    int busy_low;
    bit ok;
    logic [DB-1:0] e;
    fe_cnt = 0;
    dv_rise = 0;
    busy_low = 0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 40 * CPB; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_low++;
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_tests++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL framing_pulses got %0d want 1", fe_cnt); end
    n_tests++; if (dv_rise !== 0) begin n_fail++; $display("FAIL framing_valid got %0d deliveries want 0", dv_rise); end
    n_tests++; if (busy_low !== 0) begin n_fail++; $display("FAIL framing_busy got %0d idle cycles want 0", busy_low); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL framing_release got busy %b want 0", bus.busy); end
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
    join_none
    wait_valid(LAT + 20, ok);
    pop_exp(e);
    n_tests++; if (!ok || bus.data_out !== e) begin n_fail++; $display("FAIL framing_next got %h valid %b want %h", bus.data_out, ok, e); end
    wait fork;
    n_tests++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL framing_next_err got %0d pulses want 1", fe_cnt); end
    accept_byte();
  endtask

  task automatic test_overrun();
    logic [DB-1:0] e_first, e_drop;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    pop_exp(e_first);
    pop_exp(e_drop);
    n_tests++; if (bus.data_out !== e_first) begin n_fail++; $display("FAIL overrun_data got %h want %h (dropped %h)", bus.data_out, e_first, e_drop); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b want 1", bus.overrun); end
    n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid got %b want 1", bus.data_valid); end
    repeat (10) @(negedge clk);
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got %b want 1", bus.overrun); end
    accept_byte();
    n_tests++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_accept_valid got %b want 0", bus.data_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    int start;
    logic [DB-1:0] e1, e2;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    start = cyc;
    fork
      begin
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
      end
      begin
        // Second frame starts (DB+2)*CPB later; its delivery edge follows LAT after that.
        repeat ((DB + 2) * CPB + LAT - 1) @(negedge clk);
        pop_exp(e1);
        n_tests++; if (bus.data_out !== e1 || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %h valid %b want %h", bus.data_out, bus.data_valid, e1); end
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        pop_exp(e2);
        n_tests++; if (bus.data_out !== e2) begin n_fail++; $display("FAIL b2b_load got %h want %h", bus.data_out, e2); end
        n_tests++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", bus.data_valid); end
      end
    join
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
    n_tests++; if (bus.data_out !== 8'hAA) begin n_fail++; $display("FAIL b2b_hold got %h want aa", bus.data_out); end
    accept_byte();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [DB-1:0] e;
    fe_cnt = 0;
    // 0xF0 has zeros in bits 0..3, so the line stays low through start and bits 0..2.
    rx = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got %b want 1", bus.busy); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL midframe_async got busy %b valid %b want 0 0", bus.busy, bus.data_valid); end
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL midframe_data got %h want 00", bus.data_out); end
    n_tests++; if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL midframe_flags got fe %b ov %b want 0 0", bus.frame_err, bus.overrun); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    dv_rise = 0;
    exp_q.push_back(8'h0F);
    fork
      send_frame(8'h0F, 1'b1);
    join_none
    wait_valid(LAT + 20, ok);
    pop_exp(e);
    n_tests++; if (!ok || bus.data_out !== e) begin n_fail++; $display("FAIL midframe_next got %h valid %b want %h", bus.data_out, ok, e); end
    wait fork;
    repeat (CPB) @(negedge clk);
    n_tests++; if (dv_rise !== 1) begin n_fail++; $display("FAIL midframe_count got %0d deliveries want 1", dv_rise); end
    n_tests++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL midframe_frame_err got %0d pulses want 0", fe_cnt); end
    accept_byte();
  endtask

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    bus.data_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_receiver

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Standalone 8N1 UART receive endpoint: it deserialises a line driven by the existing uart transmit path into parallel bytes.
- Bytes are delivered through a valid/ready handshake, with framing-error and overrun reporting.
- It sits between an external serial pin (or another uart instance's Tx) and a byte consumer.
- A single receive-only block is used wherever the full combined uart is not needed.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and ≥4.
- DATA_BITS, 8, payload bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- data_out  output  DATA_BITS  received byte; stable while data_valid=1.
- data_valid  output  1  byte available.
- data_ready  input  1  consumer accepts the byte (transfer occurs when data_valid&&data_ready at a clk edge).
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  sticky: a completed byte was dropped.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - state=IDLE, counters=0.
  - Both synchronizer flops are set to 1 (line idle).
  - Reset asserted mid-frame aborts the frame; after release the receiver waits for a fresh falling edge.
- Input path:
  - rx passes through a 2-flop synchronizer; rx_s is the second-flop output.
  - An edge detector registers rx_s_d.
  - fall = rx_s_d & ~rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on fall → START, bit_cnt_clk=0. Call this detection cycle T0.
  - START: at T0+CLKS_PER_BIT/2, sample rx_s.
    - 0 → DATA, clk counter reset, bit_idx=0.
    - 1 → IDLE (glitch rejected; no flags).
  - DATA: sample bit i at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT.
    - Bits shift into the shift register LSB first: the register shifts right and the new bit enters at the MSB.
    - After bit DATA_BITS-1 → STOP.
  - STOP: sample at T0+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT.
    - 1 → deliver byte, → IDLE.
    - 0 → frame_err=1 for exactly the next cycle, byte discarded, → BREAK.
  - BREAK: stay until rx_s=1, then → IDLE. A held-low line produces exactly one frame_err.
- Delivery (registered; visible the cycle after the stop sample):
  - data_valid=0 → data_out←shift register, data_valid←1.
  - data_valid=1 and data_ready=1 in the same cycle → load new byte; data_valid stays 1; no overrun.
  - data_valid=1 and data_ready=0 → new byte dropped, data_out unchanged, overrun←1.
- Handshake:
  - data_valid&&data_ready with no new byte → data_valid←0 next cycle.
  - data_out holds its value after acceptance until the next load.
  - overrun clears on the first accepted transfer after it was set. It is cleared by reset only otherwise.
- Latency:
  - rx pin falling edge to T0 = 3 clk edges (2 synchronizer stages + edge register).
  - Stop sample to data_valid = 1 cycle.
- Back-to-back frames:
  - After delivery the FSM is in IDLE with half a bit time remaining in the stop bit.
  - A start bit immediately following the stop bit is detected without loss.
- Counters: clk counter is $clog2(CLKS_PER_BIT) bits and wraps only via explicit reset at each sample point. bit_idx is $clog2(DATA_BITS) bits.

Decomposition:
- Shared package uart_pkg:
  - state enum uart_rx_state_t (IDLE, START, DATA, STOP, BREAK).
  - default constants UART_CLKS_PER_BIT=16 and UART_DATA_BITS=8, shared with the transmit side.
- One sub-module, uart_sync2:
  - 2-flop synchronizer with parameterised reset value 1, same clk and reset.
  - Reused for any asynchronous pin in the codebase.

Test Plan (CLKS_PER_BIT=16):
- Single frame:
  - Stimulus: send 0xF5 (bits 1,0,1,0,1,1,1,1 LSB first); data_ready held 0.
  - Response: data_valid rises 1 cycle after the stop sample; data_out=0xF5; frame_err=0, overrun=0; data_valid stays 1 until data_ready=1, then drops the next cycle.
- Glitch: rx low for 4 clk then high → stays IDLE; no data_valid, no frame_err; busy returns to 0 by T0+9.
- Framing error:
  - Stimulus: send 0x3C with stop bit 0, line then held low for 40 bit times, then released.
  - Response: exactly one frame_err pulse; no data_valid; busy=1 throughout BREAK; a following 0xA5 frame received correctly.
- Overrun: send 0x11 then 0x22 back-to-back with data_ready=0 → data_out=0x11, overrun=1; assert data_ready → data_valid=0 and overrun=0 next cycle.
- Simultaneous accept/load: send 0x55 then 0xAA with data_ready pulsed exactly in the cycle 0xAA is delivered → data_out=0xAA, data_valid stays 1, overrun=0.
- Reset mid-frame:
  - Stimulus: assert reset during bit 3 of 0xF0; release; send 0x0F.
  - Response: all outputs return to reset values immediately; only 0x0F is delivered; no frame_err.
